alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Keeps the existing 4-bit opcode encoding. Adds a valid/ready handshake on input and output, registered result and flags, and a full flag set (carry, oflow, eq, zero, neg, err).
- Adds an optional iterative shift-add multiply.
- Sits between the decode stage and writeback. It owns its operands from accept until the result is taken.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- SHW, $clog2(WIDTH)+1, width of the shift-amount field taken from b[SHW-1:0]; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and sel are valid.
- in_ready  out  1  block accepts in this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (shift amount for SLL).
- sel  in  4  opcode: 0001 ADD, 0010 SUB, 0101 AND, 0110 OR, 0111 NOT(a), 1000 XOR, 1001 SLL, 1011 MOV(a), 1100 MUL.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  WIDTH  result.
- carry  out  1  carry/no-borrow/shifted-out bit/multiply high-half-nonzero.
- oflow  out  1  signed overflow (ADD/SUB only).
- eq  out  1  a == b, for every opcode.
- zero  out  1  out == 0.
- neg  out  1  out[WIDTH-1].
- err  out  1  illegal opcode.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst=1 at a clock edge, from any state, including mid-MUL): next state IDLE. out_valid, out and all flags go to 0. Any in-flight operation is dropped with no output.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back accepts.
- Accept occurs at an edge where in_valid && in_ready; a, b and sel are captured.
- Single-cycle ops (all except MUL, including illegal opcodes):
  - Result and flags are registered at the accept edge.
  - State goes to DONE and out_valid=1 in the next cycle; latency 1.
- MUL:
  - The accept edge loads the multiplicand, multiplier and a 2*WIDTH accumulator, and sets count=WIDTH. State goes to BUSY.
  - Each BUSY cycle processes one multiplier bit (LSB first) and decrements count.
  - The edge where count reaches 0 enters DONE. out_valid=1 exactly WIDTH cycles after the accept edge.
  - in_ready=0 throughout BUSY.
- DONE:
  - out and flags hold stable until out_valid && out_ready.
  - Take with no new accept: next state IDLE, out_valid=0. out and flags keep their last values.
  - Take with a simultaneous new accept: the new op is processed per its type, with no bubble for single-cycle ops.
- ADD:
  - out = (a+b) mod 2^WIDTH; carry = carry out of bit WIDTH-1.
  - oflow = 1 when a and b have equal MSBs and out's MSB differs.
- SUB:
  - out = a + ~b + 1; carry = 1 when a >= b unsigned (no borrow).
  - oflow = 1 when a and b have differing MSBs and out's MSB differs from a's MSB.
- AND, OR, XOR, NOT(a), MOV(a): bitwise; carry=0, oflow=0.
- SLL:
  - sh = b[SHW-1:0]; out = a << sh, so out=0 when sh >= WIDTH.
  - carry = a[WIDTH-sh] for 1<=sh<=WIDTH, else 0. oflow=0.
- MUL:
  - out = low WIDTH bits of the unsigned product.
  - carry = 1 if the high WIDTH bits are nonzero. oflow=0.
- Illegal opcode (0000, 0011, 0100, 1010, 1101-1111, and 1100 when MUL is compiled out):
  - Completes as a single-cycle op with out=0, err=1 and carry=oflow=0.
  - zero=1; eq still reflects a==b.
- err=0 for every legal op.
- zero, neg and eq are always computed from the registered out and the captured operands.
- No $display or other simulation side effects.

Optional Feature:
- ALU_SEQ_MUL_EN defined: opcode 1100 is MUL as above; BUSY state, counter and accumulator are present.
- Not defined: BUSY state and multiply datapath are absent. 1100 is illegal (err=1, latency 1), and in_ready never drops for a multi-cycle op.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=0x00000001 -> 1 cycle later out=0x80000000, oflow=1, carry=0, neg=1, zero=0, err=0.
- SUB a=5 b=5 -> out=0, zero=1, eq=1, carry=1, oflow=0. SUB a=3 b=5 -> out=0xFFFFFFFE, carry=0, neg=1.
- SLL a=0x80000001 with b=1 -> out=0x00000002, carry=1. With b=32 -> out=0, carry=1. With b=33 -> out=0, carry=0.
- Back-to-back with out_ready held 1: XOR a=0xF0F0F0F0 b=0xFFFF0000, then AND on the next cycle.
  - Expect in_ready=1 every cycle.
  - Results 0x0F0FF0F0 then 0xF0F00000 on consecutive cycles.
  - Holding out_ready=0 keeps the first result stable and in_ready=0.
- ALU_SEQ_MUL_EN defined, MUL a=0x00010000 b=0x00010000:
  - in_ready=0 for 32 cycles; out_valid exactly 32 cycles after accept.
  - out=0, carry=1, zero=1.
  - Repeat with rst asserted at BUSY cycle 10: next cycle state IDLE, out_valid=0, out=0, no stale result.
- sel=1101 -> out=0, err=1, zero=1, latency 1. sel=1100 without ALU_SEQ_MUL_EN -> err=1, latency 1.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered ALU with valid/ready handshakes and a full flag set.
//            Define ALU_SEQ_MUL_EN to build in the iterative shift-add MUL.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             oflow,
  output logic             eq,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH) + 1;

  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_AND = 4'b0101;
  localparam logic [3:0] c_OP_OR  = 4'b0110;
  localparam logic [3:0] c_OP_NOT = 4'b0111;
  localparam logic [3:0] c_OP_XOR = 4'b1000;
  localparam logic [3:0] c_OP_SLL = 4'b1001;
  localparam logic [3:0] c_OP_MOV = 4'b1011;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] c_OP_MUL = 4'b1100;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    S_BUSY = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_oflow;
  logic             r_eq;
  logic             r_zero;
  logic             r_neg;
  logic             r_err;

  logic             w_accept;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_oflow;
  logic             w_err;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH:0]   w_shl;
  logic [SHW-1:0]   w_sh;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;
  logic               r_eq_cap;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  assign out   = r_out;
  assign carry = r_carry;
  assign oflow = r_oflow;
  assign eq    = r_eq;
  assign zero  = r_zero;
  assign neg   = r_neg;
  assign err   = r_err;

  // One spare top bit turns the carry-out, borrow and last-shifted-out bit
  // into a plain bit select.
  assign w_sh  = b[SHW-1:0];
  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_dif = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shl = {1'b0, a} << w_sh;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_oflow = 1'b0;
    w_err   = 1'b0;
    case (sel)
      c_OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_oflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res   = w_dif[WIDTH-1:0];
        w_carry = w_dif[WIDTH];
        w_oflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_AND: w_res = a & b;
      c_OP_OR:  w_res = a | b;
      c_OP_NOT: w_res = ~a;
      c_OP_XOR: w_res = a ^ b;
      c_OP_MOV: w_res = a;
      c_OP_SLL: begin
        w_res   = w_shl[WIDTH-1:0];
        w_carry = w_shl[WIDTH];
      end
`ifdef ALU_SEQ_MUL_EN
      c_OP_MUL: w_res = '0;
`endif
      default:  w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_oflow <= 1'b0;
      r_eq    <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_eq_cap <= 1'b0;
`endif
    end else if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
      if (sel == c_OP_MUL) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_cnt    <= SHW'(WIDTH);
        r_eq_cap <= (a == b);
        r_state  <= S_BUSY;
      end else
`endif
      begin
        r_out   <= w_res;
        r_carry <= w_carry;
        r_oflow <= w_oflow;
        r_eq    <= (a == b);
        r_zero  <= (w_res == '0);
        r_neg   <= w_res[WIDTH-1];
        r_err   <= w_err;
        r_state <= S_DONE;
      end
    end else if ((r_state == S_DONE) && out_ready) begin
      r_state <= S_IDLE;
`ifdef ALU_SEQ_MUL_EN
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      // Last multiplier bit: publish straight from the final partial sum.
      if (r_cnt == SHW'(1)) begin
        r_out   <= w_acc_nxt[WIDTH-1:0];
        r_carry <= (w_acc_nxt[2*WIDTH-1:WIDTH] != '0);
        r_oflow <= 1'b0;
        r_eq    <= r_eq_cap;
        r_zero  <= (w_acc_nxt[WIDTH-1:0] == '0);
        r_neg   <= w_acc_nxt[WIDTH-1];
        r_err   <= 1'b0;
        r_state <= S_DONE;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=32), optional MUL aware.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   sel = 4'b0000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         carry, oflow, eq, zero, neg, err;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out),
    .carry(carry), .oflow(oflow), .eq(eq), .zero(zero), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  // flags packed as {carry, oflow, eq, zero, neg, err}
  typedef struct {
    logic [W-1:0] o;
    logic [5:0]   f;
    int           rdy;
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_mul(input logic [3:0] s);
`ifdef ALU_SEQ_MUL_EN
    return s == 4'b1100;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W:0]   t;
    logic [63:0]  p;
    logic [W-1:0] r;
    logic         c, o, er;
    int           sh;
    r = '0; c = 1'b0; o = 1'b0; er = 1'b0;
    case (s)
      4'b0001: begin
        t = {1'b0, x} + {1'b0, y};
        r = t[W-1:0]; c = t[W];
        o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'b0010: begin
        r = x - y; c = (x >= y);
        o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'b0101: r = x & y;
      4'b0110: r = x | y;
      4'b0111: r = ~x;
      4'b1000: r = x ^ y;
      4'b1011: r = x;
      4'b1001: begin
        sh = int'(y[5:0]);
        r  = (sh >= W) ? '0 : (x << sh);
        if (sh >= 1 && sh <= W) c = x[W-sh];
      end
      default: begin
        if (is_mul(s)) begin
          p = 64'(x) * 64'(y);
          r = p[W-1:0];
          c = (p[63:32] != 0);
        end else begin
          er = 1'b1;
        end
      end
    endcase
    e.o   = r;
    e.f   = {c, o, (x == y), (r == '0), r[W-1], er};
    e.rdy = 0;
    return e;
  endfunction

  // Reference: at most one op in flight; outputs either show the pending
  // result once its latency has elapsed, or the last taken/reset values.
  exp_t q[$];
  exp_t last;
  exp_t cur;
  exp_t nxt;
  bit   mon_en = 1'b0;
  int   ncyc = 0;
  logic m_ev, m_ir;

  always @(negedge clk) begin
    if (mon_en) begin
      ncyc++;
      m_ev = (q.size() > 0) && (ncyc >= q[0].rdy);
      m_ir = (q.size() == 0) || (m_ev && out_ready);
      cur  = m_ev ? q[0] : last;
      chk("mon_out_valid", 64'(out_valid), 64'(m_ev));
      chk("mon_in_ready", 64'(in_ready), 64'(m_ir));
      chk("mon_out", 64'(out), 64'(cur.o));
      chk("mon_flags", 64'({carry, oflow, eq, zero, neg, err}), 64'(cur.f));
      if (rst) begin
        q.delete();
        last = '{o: '0, f: '0, rdy: 0};
      end else begin
        if (m_ev && out_ready) last = q.pop_front();
        if (in_valid && m_ir) begin
          nxt = model(sel, a, b);
          nxt.rdy = ncyc + (is_mul(sel) ? W : 1);
          q.push_back(nxt);
        end
      end
    end
  end

  task automatic send(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok;
    ok = 1'b0;
    sel = s; a = x; b = y; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for sel=%b", s);
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic run(input string nm, input logic [3:0] s, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] eo, input logic [5:0] ef,
                     input int elat);
    int lat;
    send(s, x, y);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_out"}, 64'(out), 64'(eo));
    chk({nm, "_flags"}, 64'({carry, oflow, eq, zero, neg, err}), 64'(ef));
    @(posedge clk); #1;
  endtask

  bit rnd_en = 1'b0;
  always @(posedge clk) begin
    if (rnd_en) #1 out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0] ops [11];
  int         saw_valid;

  initial begin
    ops = '{4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
            4'b1001, 4'b1011, 4'b1100, 4'b1101, 4'b0000};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_flags", 64'({carry, oflow, eq, zero, neg, err}), 64'd0);
    @(posedge clk); #1;

    run("add_ovf",  4'b0001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 6'b010010, 1);
    run("sub_eq",   4'b0010, 32'd5, 32'd5, 32'h0000_0000, 6'b101100, 1);
    run("sub_brw",  4'b0010, 32'd3, 32'd5, 32'hFFFF_FFFE, 6'b000010, 1);
    run("sll_1",    4'b1001, 32'h8000_0001, 32'd1,  32'h0000_0002, 6'b100000, 1);
    run("sll_32",   4'b1001, 32'h8000_0001, 32'd32, 32'h0000_0000, 6'b100100, 1);
    run("sll_33",   4'b1001, 32'h8000_0001, 32'd33, 32'h0000_0000, 6'b000100, 1);
    run("illegal",  4'b1101, 32'd7, 32'd9, 32'h0000_0000, 6'b000101, 1);

    // back-to-back XOR then AND with the consumer always ready
    send(4'b1000, 32'hF0F0_F0F0, 32'hFFFF_0000);
    sel = 4'b0101; a = 32'hF0F0_F0F0; b = 32'hFFFF_0000; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    chk("b2b_xor_out", 64'(out), 64'h0F0F_F0F0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_and_valid", 64'(out_valid), 64'd1);
    chk("b2b_and_out", 64'(out), 64'hF0F0_0000);
    @(posedge clk); #1;

    // consumer stall holds the result and blocks the next op
    out_ready = 1'b0;
    send(4'b1000, 32'hF0F0_F0F0, 32'hFFFF_0000);
    sel = 4'b0101; a = 32'hF0F0_F0F0; b = 32'hFFFF_0000; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_out", 64'(out), 64'h0F0F_F0F0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stall_and_out", 64'(out), 64'hF0F0_0000);
    @(posedge clk); #1;

`ifdef ALU_SEQ_MUL_EN
    run("mul_hi",  4'b1100, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 6'b101100, 32);
    run("mul_max", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 6'b101000, 32);
    run("mul_sm",  4'b1100, 32'd7, 32'd9, 32'd63, 6'b000000, 32);
    // reset in the tenth BUSY cycle drops the multiply
    send(4'b1100, 32'h0001_0000, 32'h0001_0000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mulrst_out_valid", 64'(out_valid), 64'd0);
    chk("mulrst_out", 64'(out), 64'd0);
    chk("mulrst_in_ready", 64'(in_ready), 64'd1);
    saw_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw_valid++;
    end
    chk("mulrst_no_stale", 64'(saw_valid), 64'd0);
    @(posedge clk); #1;
`else
    run("mul_off", 4'b1100, 32'd3, 32'd4, 32'h0000_0000, 6'b000101, 1);
`endif

    // mixed traffic against the reference with a randomly stalling consumer
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++)
      send(ops[$urandom_range(0, 10)], 32'($urandom), 32'($urandom));
    rnd_en = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
